// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extender (sign/zero/high-place/prefix-load); optional flush port with IMMX_FLUSH_EN
module imm_extend_unit #(
  parameter int IMM_W = 14,
  parameter int OUT_W = 16,
  parameter int PFX_W = OUT_W - IMM_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef IMMX_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_pfx
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PREFIXED = 1'b1;
  logic [0:0] state;
  logic [PFX_W-1:0] pfx_q;
  logic fl, acc, is_pfx, use_pfx;
  logic [OUT_W-1:0] nxt;
`ifdef IMMX_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  assign in_ready = !fl && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign is_pfx = in_mode == 2'b11;
  assign use_pfx = state == PREFIXED && !in_mode[1];
  always_comb begin
    nxt = in_mode == 2'b10 ? {{PFX_W{1'b0}}, in_imm} << PFX_W
        : use_pfx ? {pfx_q, in_imm}
        : in_mode[0] ? {{PFX_W{1'b0}}, in_imm}
        : {{PFX_W{in_imm[IMM_W-1]}}, in_imm};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_pfx <= 1'b0;
      pfx_q <= '0;
      state <= IDLE;
    end else if (fl) begin
      out_valid <= 1'b0;
      state <= IDLE;
    end else begin
      if (acc && !is_pfx) begin
        out_valid <= 1'b1;
        out_data <= nxt;
        out_pfx <= use_pfx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc) begin
        state <= is_pfx ? PREFIXED : IDLE;
        if (is_pfx) pfx_q <= in_imm[PFX_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: randomized scoreboard bench for imm_extend_unit against an arithmetic model
module tb_imm_extend_unit;
  localparam int IMM_W = 14;
  localparam int OUT_W = 16;
  localparam int PFX_W = OUT_W - IMM_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_mode = 2'b00;
  logic [IMM_W-1:0] in_imm = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic out_pfx;
  int n_chk = 0;
  int n_fail = 0;
  longint qd[$];
  bit qp[$];
  bit pend = 0;
  longint pfx = 0;
  longint last = 0;
  bit ov_m = 0;

  imm_extend_unit #(.IMM_W(IMM_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef IMMX_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_imm(in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pfx(out_pfx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int m, input longint imm);
    longint r;
    bit p;
    if (m == 3) begin
      pfx = imm % (longint'(1) << PFX_W);
      pend = 1;
      return;
    end
    p = pend && m != 2;
    if (m == 2) r = (imm * (longint'(1) << PFX_W)) % (longint'(1) << OUT_W);
    else if (p) r = pfx * (longint'(1) << IMM_W) + imm;
    else if (m == 1 || imm < (longint'(1) << (IMM_W - 1))) r = imm;
    else r = imm + (longint'(1) << OUT_W) - (longint'(1) << IMM_W);
    pend = 0;
    qd.push_back(r);
    qp.push_back(p);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      ov_m = qd.size() != 0;
      chk("out_valid", out_valid, ov_m);
      if (out_valid && ov_m) begin
        chk("out_data", out_data, qd[0]);
        chk("out_pfx", out_pfx, qp[0]);
        if (out_ready) begin
          last = qd.pop_front();
          void'(qp.pop_front());
        end
      end else if (!out_valid) begin
        chk("idle_hold", out_data, last);
      end
    end
  end

  task automatic step(input bit v, input int m, input int imm, input bit rdy);
    @(posedge clk);
    #1;
    in_valid = v;
    in_mode = 2'(m);
    in_imm = IMM_W'(imm);
    out_ready = rdy;
    @(negedge clk);
    #1;
    chk("in_ready", in_ready, !flush && (!ov_m || out_ready));
    if (in_valid && in_ready) model(m, longint'(in_imm));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pfx", out_pfx, 0);
    qd.delete();
    qp.delete();
    pend = 0;
    last = 0;
    #1;
    rst_n = 1;
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pfx", out_pfx, 0);
    #20;
    rst_n = 1;
    step(1, 0, 'h2FFF, 1);
    step(1, 0, 'h0FFF, 1);
    step(1, 1, 'h2FFF, 1);
    step(1, 2, 'h0001, 1);
    step(1, 2, 'h3FFF, 1);
    step(1, 3, 'h0002, 1);
    step(0, 0, 0, 1);
    step(1, 0, 'h2000, 1);
    step(1, 0, 'h2000, 1);
    step(1, 3, 'h0001, 1);
    step(1, 3, 'h0003, 1);
    step(1, 1, 'h0005, 1);
    step(1, 3, 'h0003, 1);
    step(1, 2, 'h0001, 1);
    step(1, 1, 'h0001, 1);
    step(0, 0, 0, 1);
    step(1, 0, 'h1234, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 'h0777, 0);
      chk("bp_ready", in_ready, 0);
    end
    step(1, 1, 'h0777, 1);
    step(0, 0, 0, 1);
    step(1, 3, 'h0002, 1);
    do_reset();
    step(1, 0, 'h0001, 1);
    step(0, 0, 0, 1);
`ifdef IMMX_FLUSH_EN
    step(1, 3, 'h0002, 1);
    @(posedge clk);
    #1;
    flush = 1;
    in_valid = 1;
    in_mode = 2'b00;
    in_imm = 'h0005;
    @(negedge clk);
    #1;
    chk("flush_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    qd.delete();
    qp.delete();
    pend = 0;
    step(1, 0, 'h0001, 1);
    step(0, 0, 0, 1);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, (1 << IMM_W) - 1), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("drained", qd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
